ysyx_22050854_fetch_ctrl: RTL and testbench
===========================================

Name: ysyx_22050854_fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the fetch pointer and drives the instruction-memory request/response handshake. It feeds one instruction at a time into the IF/ID register. It accepts redirects (taken branch/jal/jalr/ecall/mret) from the ID-stage PC unit and discards any wrong-path fetch still in flight. It sits between the PC unit (redirect source), the IF/ID pipeline register (consumer) and the instruction memory port.

Parameters:
RESET_PC, 32'h80000000, fetch address loaded on reset.

Ports:
clk  input  1  clock.
rst  input  1  reset.
redirect_valid  input  1  ID-stage jump taken this cycle.
redirect_pc  input  32  target address, valid when redirect_valid=1.
id_stall  input  1  IF/ID cannot accept (data conflict or suspend).
imem_req_valid  output  1  fetch request.
imem_req_addr  output  32  fetch address.
imem_req_ready  input  1  memory accepts request.
imem_resp_valid  input  1  instruction returned.
imem_resp_data  input  32  instruction word.
if_valid  output  1  if_pc/if_inst hold a valid instruction for IF/ID.
if_pc  output  32  PC of the buffered instruction.
if_inst  output  32  buffered instruction.
fetch_pc  output  32  current fetch pointer.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state changes occur on the posedge of clk.
- Reset values: state=IDLE, fetch_pc=RESET_PC, if_valid=0, if_pc=0, if_inst=0, imem_req_valid=0. rst has priority over everything, including mid-transaction. A response arriving after reset is ignored because the state is IDLE or REQ.
- States: IDLE, REQ, WAIT, HOLD, DRAIN. At most one request is outstanding.
- IDLE: the cycle after rst deasserts, go to REQ.
- REQ:
  - imem_req_valid=1 and imem_req_addr=fetch_pc.
  - Handshake (imem_req_valid & imem_req_ready) with no redirect: go to WAIT.
  - Redirect with no handshake: fetch_pc<=redirect_pc, stay in REQ. The address changes next cycle.
  - Redirect together with a handshake: fetch_pc<=redirect_pc, go to DRAIN.
- WAIT (imem_req_valid=0):
  - imem_resp_valid with no redirect: if_pc<=fetch_pc, if_inst<=imem_resp_data, if_valid<=1, fetch_pc<=fetch_pc+4, go to HOLD.
  - imem_resp_valid with redirect: discard the response, fetch_pc<=redirect_pc, go to REQ.
  - Redirect with no response: fetch_pc<=redirect_pc, go to DRAIN.
- DRAIN:
  - Wait for the stale response. On imem_resp_valid, discard it and go to REQ.
  - Redirect in DRAIN: fetch_pc<=redirect_pc and stay in DRAIN. If the redirect coincides with the response, go to REQ with the new fetch_pc.
- HOLD (if_valid=1):
  - Redirect has priority over id_stall. On redirect: if_valid<=0 (the buffered instruction is wrong-path), fetch_pc<=redirect_pc, go to REQ.
  - Else if ~id_stall: the instruction is consumed this cycle, if_valid<=0, go to REQ.
  - Else stay in HOLD with if_pc/if_inst stable.
- if_pc and if_inst keep their last values when if_valid=0.
- Minimum latency: handshake in cycle N, response in N+1, if_valid=1 in N+2, next request in N+3. Peak throughput is 1 instruction per 3 cycles.
- fetch_pc+4 wraps modulo 2^32. No alignment check is made; redirect_pc is used as given.
- imem_resp_valid in IDLE, REQ or HOLD is a protocol violation and is ignored, with no state change.
- imem_req_addr must stay stable while imem_req_valid=1 and no redirect has occurred.

Test Plan:
- Reset, then ready=1 and response one cycle after the request, insts 0x00000013, 0x00100093 → requests to 0x80000000, 0x80000004. if_valid pulses with if_pc 0x80000000 then 0x80000004, 3 cycles apart.
- imem_req_ready=0 for 4 cycles in REQ → imem_req_valid stays 1 and imem_req_addr holds 0x80000000 throughout. State advances only on ready.
- id_stall=1 for 5 cycles in HOLD → if_valid, if_pc and if_inst stay constant. No new request until the cycle id_stall falls.
- Redirect to 0x80000100 in WAIT, response 2 cycles later → the response is discarded (if_valid stays 0) and the next request addr is 0x80000100.
- Redirect to 0x80000200 together with id_stall=1 in HOLD → if_valid=0 next cycle, then a request to 0x80000200.
- Redirect coinciding with the response in WAIT, then rst asserted mid-WAIT on the next fetch → the first response is dropped and a request goes to redirect_pc. After rst: fetch_pc=0x80000000, if_valid=0, and the late response is ignored.

Source files
------------

// File: rtl/ysyx_22050854_fetch_ctrl.sv
// ysyx_22050854_fetch_ctrl
// Instruction-fetch sequencer. Owns the fetch pointer, issues one instruction
// memory request at a time, buffers the returned word for the IF/ID register
// and discards wrong-path fetches when the ID stage redirects the PC.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   redirect_valid    ID-stage jump taken this cycle
//   redirect_pc       jump target, valid with redirect_valid
//   id_stall          IF/ID cannot accept the buffered instruction
//   imem_req_valid    fetch request to instruction memory
//   imem_req_addr     fetch address
//   imem_req_ready    memory accepts the request
//   imem_resp_valid   instruction word returned
//   imem_resp_data    instruction word
//   if_valid          if_pc/if_inst hold a valid instruction
//   if_pc, if_inst    buffered PC and instruction
//   fetch_pc          current fetch pointer
module ysyx_22050854_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] fetch_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc_nxt;
  logic        if_valid_nxt;
  logic [31:0] if_pc_nxt;
  logic [31:0] if_inst_nxt;
  logic        handshake;

  // The request is a pure function of state, so the address cannot move
  // while the request is pending unless fetch_pc itself is redirected.
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = fetch_pc;
  assign handshake      = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if_valid <= if_valid_nxt;
      if_pc    <= if_pc_nxt;
      if_inst  <= if_inst_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if_valid_nxt = if_valid;
    if_pc_nxt    = if_pc;
    if_inst_nxt  = if_inst;
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          // An accepted request is now wrong-path; its response must be drained.
          state_nxt    = handshake ? S_DRAIN : S_REQ;
        end else if (handshake) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc;
            state_nxt    = S_REQ;
          end else begin
            if_pc_nxt    = fetch_pc;
            if_inst_nxt  = imem_resp_data;
            if_valid_nxt = 1'b1;
            fetch_pc_nxt = fetch_pc + 32'd4;
            state_nxt    = S_HOLD;
          end
        end else if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          state_nxt    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) fetch_pc_nxt = redirect_pc;
        if (imem_resp_valid) state_nxt = S_REQ;
      end
      S_HOLD: begin
        // A redirect kills the buffered instruction even if ID is stalled.
        if (redirect_valid) begin
          if_valid_nxt = 1'b0;
          fetch_pc_nxt = redirect_pc;
          state_nxt    = S_REQ;
        end else if (!id_stall) begin
          if_valid_nxt = 1'b0;
          state_nxt    = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050854_fetch_ctrl.sv
module tb_ysyx_22050854_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] fetch_pc;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22050854_fetch_ctrl #(.RESET_PC(32'h80000000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .fetch_pc       (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs set before step() are sampled at the next posedge; outputs are
  // observed 1 time unit after that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    id_stall        = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
  endtask

  // Reset, then release; leaves the DUT in REQ at RESET_PC.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    n_tests++; if (fetch_pc !== 32'h80000000) begin n_fail++; $display("FAIL reset_fetch_pc got %h exp 80000000", fetch_pc); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got %b exp 0", if_valid); end
    n_tests++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc got %h exp 0", if_pc); end
    n_tests++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_if_inst got %h exp 0", if_inst); end
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    rst = 1'b0;
    step();
    n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000000) begin n_fail++; $display("FAIL idle_to_req got v=%b a=%h exp v=1 a=80000000", imem_req_valid, imem_req_addr); end
  endtask

  // Two back-to-back fetches with single-cycle memory latency.
  task automatic test_back_to_back();
    logic [31:0] insts [2];
    insts[0] = 32'h00000013;
    insts[1] = 32'h00100093;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000000 + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_req%0d got v=%b a=%h exp a=%h", i, imem_req_valid, imem_req_addr, 32'h80000000 + 32'(4 * i)); end
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      n_tests++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_wait%0d got req_v=%b if_v=%b exp 0 0", i, imem_req_valid, if_valid); end
      imem_resp_valid = 1'b1;
      imem_resp_data  = insts[i];
      step();
      imem_resp_valid = 1'b0;
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h80000000 + 32'(4 * i) || if_inst !== insts[i]) begin n_fail++; $display("FAIL b2b_hold%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h", i, if_valid, if_pc, if_inst, 32'h80000000 + 32'(4 * i), insts[i]); end
      n_tests++; if (fetch_pc !== 32'h80000004 + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_fpc%0d got %h exp %h", i, fetch_pc, 32'h80000004 + 32'(4 * i)); end
      step();
      n_tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_consume%0d got if_v=%b req_v=%b exp 0 1", i, if_valid, imem_req_valid); end
    end
  endtask

  task automatic test_ready_low();
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000000) begin n_fail++; $display("FAIL ready_low%0d got v=%b a=%h exp v=1 a=80000000", i, imem_req_valid, imem_req_addr); end
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ready_accept got %b exp 0", imem_req_valid); end
  endtask

  // Continues from WAIT after test_ready_low.
  task automatic test_stall();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdeadbeef;
    id_stall        = 1'b1;
    step();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h80000000 || if_inst !== 32'hdeadbeef || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall%0d got v=%b pc=%h inst=%h req=%b exp 1 80000000 deadbeef 0", i, if_valid, if_pc, if_inst, imem_req_valid); end
      if (i < 4) step();
    end
    id_stall = 1'b0;
    step();
    n_tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000004) begin n_fail++; $display("FAIL stall_release got if_v=%b req=%b a=%h exp 0 1 80000004", if_valid, imem_req_valid, imem_req_addr); end
  endtask

  // Continues from REQ at 0x80000004.
  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000100;
    step();
    redirect_valid = 1'b0;
    n_tests++; if (imem_req_valid !== 1'b0 || fetch_pc !== 32'h80000100) begin n_fail++; $display("FAIL redir_wait_drain got req=%b fpc=%h exp 0 80000100", imem_req_valid, fetch_pc); end
    step();
    n_tests++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_wait_hold got req=%b if_v=%b exp 0 0", imem_req_valid, if_valid); end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h11111111;
    step();
    imem_resp_valid = 1'b0;
    n_tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000100) begin n_fail++; $display("FAIL redir_wait_req got if_v=%b req=%b a=%h exp 0 1 80000100", if_valid, imem_req_valid, imem_req_addr); end
  endtask

  // Continues from REQ at 0x80000100.
  task automatic test_redirect_hold();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h22222222;
    step();
    imem_resp_valid = 1'b0;
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h80000100 || fetch_pc !== 32'h80000104) begin n_fail++; $display("FAIL redir_hold_fill got v=%b pc=%h fpc=%h exp 1 80000100 80000104", if_valid, if_pc, fetch_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000200;
    id_stall       = 1'b1;
    step();
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    n_tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000200) begin n_fail++; $display("FAIL redir_hold got if_v=%b req=%b a=%h exp 0 1 80000200", if_valid, imem_req_valid, imem_req_addr); end
    n_tests++; if (if_pc !== 32'h80000100 || if_inst !== 32'h22222222) begin n_fail++; $display("FAIL redir_hold_keep got pc=%h inst=%h exp 80000100 22222222", if_pc, if_inst); end
  endtask

  // Continues from REQ at 0x80000200.
  task automatic test_redirect_resp_rst();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h33333333;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h80000300;
    step();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    n_tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000300) begin n_fail++; $display("FAIL redir_resp got if_v=%b req=%b a=%h exp 0 1 80000300", if_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    n_tests++; if (fetch_pc !== 32'h80000000 || if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_rst got fpc=%h if_v=%b req=%b exp 80000000 0 0", fetch_pc, if_valid, imem_req_valid); end
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h44444444;
    step();
    n_tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000000) begin n_fail++; $display("FAIL late_resp_idle got if_v=%b req=%b a=%h exp 0 1 80000000", if_valid, imem_req_valid, imem_req_addr); end
    step();
    imem_resp_valid = 1'b0;
    n_tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || if_inst !== 32'h0) begin n_fail++; $display("FAIL late_resp_req got if_v=%b req=%b inst=%h exp 0 1 0", if_valid, imem_req_valid, if_inst); end
  endtask

  // Redirects in REQ (with and without handshake), redirect coinciding with
  // the drained response, and fetch_pc wrap-around.
  task automatic test_redirect_req_drain_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000400;
    step();
    n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000400) begin n_fail++; $display("FAIL redir_req got req=%b a=%h exp 1 80000400", imem_req_valid, imem_req_addr); end
    redirect_pc    = 32'h80000500;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    n_tests++; if (imem_req_valid !== 1'b0 || fetch_pc !== 32'h80000500) begin n_fail++; $display("FAIL redir_hs_drain got req=%b fpc=%h exp 0 80000500", imem_req_valid, fetch_pc); end
    redirect_valid  = 1'b1;
    redirect_pc     = 32'hfffffffc;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h55555555;
    step();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    n_tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'hfffffffc) begin n_fail++; $display("FAIL drain_redir_resp got if_v=%b req=%b a=%h exp 0 1 fffffffc", if_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h66666666;
    step();
    imem_resp_valid = 1'b0;
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'hfffffffc || if_inst !== 32'h66666666 || fetch_pc !== 32'h0) begin n_fail++; $display("FAIL wrap got v=%b pc=%h inst=%h fpc=%h exp 1 fffffffc 66666666 0", if_valid, if_pc, if_inst, fetch_pc); end
    step();
    n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_req got req=%b a=%h exp 1 0", imem_req_valid, imem_req_addr); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_back_to_back();
    test_ready_low();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_resp_rst();
    test_redirect_req_drain_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
